// File: rtl/mac_pkg.sv
// Shared widths and types for the timing-error-tolerant systolic MAC.
package mac_pkg;
    localparam int DATA_W = 8;
    localparam int PSUM_W = 24;
    localparam int PROD_W = 2 * DATA_W;

    typedef logic [DATA_W-1:0] act_t;
    typedef logic [PSUM_W-1:0] psum_t;
    typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/mac_shadow_check.sv
// Main/shadow capture of the incoming partial sum.
// A difference between the two samples marks a late arrival.
module mac_shadow_check
    import mac_pkg::*;
(
    input  logic  clk,
    input  logic  delay_clk,
    input  logic  rst_n,
    input  psum_t d,
    output psum_t psin_q,
    output psum_t psin_sh,
    output logic  mismatch
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) psin_q <= '0;
        else        psin_q <= d;
    end

    // The shadow sees the value that finally settled inside the check window.
    always_ff @(posedge delay_clk or negedge rst_n) begin
        if (!rst_n) psin_sh <= '0;
        else        psin_sh <= d;
    end

    assign mismatch = (psin_q != psin_sh);
endmodule

// File: rtl/type1_mac.sv
// Systolic PE: unsigned 8x8 MAC with Razor-style late partial-sum detection.
// On error the local product is deferred to the next PE instead of stalling.
module type1_mac
    import mac_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  act_t  weight,
    input  act_t  activation,
    input  psum_t partial_sum_in,
    input  prod_t error_product_in,
    input  logic  error_in,
    input  logic  delay_clk,
    output act_t  next_activation,
    output psum_t partial_sum_out,
    output prod_t error_product_out,
    output logic  error_out
);
    psum_t psin_q;
    psum_t psin_sh;
    logic  mismatch;
    prod_t prod_q;
    prod_t comp_q;
    act_t  act_q;
    psum_t prod_ext;
    psum_t comp_ext;

    mac_shadow_check u_check (
        .clk      (clk),
        .delay_clk(delay_clk),
        .rst_n    (rst_n),
        .d        (partial_sum_in),
        .psin_q   (psin_q),
        .psin_sh  (psin_sh),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            comp_q <= '0;
            act_q  <= '0;
        end else begin
            prod_q <= PROD_W'(weight) * PROD_W'(activation);
            comp_q <= error_in ? error_product_in : '0;
            act_q  <= activation;
        end
    end

    assign prod_ext = {{(PSUM_W-PROD_W){1'b0}}, prod_q};
    assign comp_ext = {{(PSUM_W-PROD_W){1'b0}}, comp_q};

    // Upstream compensation is always folded in; only the local product defers.
    always_comb begin
        partial_sum_out   = psin_q + prod_ext + comp_ext;
        error_product_out = '0;
        error_out         = 1'b0;
        if (mismatch) begin
            partial_sum_out   = psin_sh + comp_ext;
            error_product_out = prod_q;
            error_out         = 1'b1;
        end
    end

    assign next_activation = act_q;
endmodule

// File: tb/tb_type1_mac.sv
// Directed self-checking bench for type1_mac.
// Outputs are sampled on clk negedge, after the delay_clk check edge.
module tb_type1_mac;
    import mac_pkg::*;

    logic  clk = 1'b0;
    logic  delay_clk = 1'b0;
    logic  rst_n = 1'b0;
    act_t  weight = '0;
    act_t  activation = '0;
    psum_t partial_sum_in = '0;
    prod_t error_product_in = '0;
    logic  error_in = 1'b0;
    act_t  next_activation;
    psum_t partial_sum_out;
    prod_t error_product_out;
    logic  error_out;

    int passed = 0;
    int total = 0;

    // clk rises at 5,15,...; delay_clk rises 3 ns later
    always #5 clk = ~clk;
    initial begin
        #3;
        forever #5 delay_clk = ~delay_clk;
    end

    type1_mac dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .weight           (weight),
        .activation       (activation),
        .partial_sum_in   (partial_sum_in),
        .error_product_in (error_product_in),
        .error_in         (error_in),
        .delay_clk        (delay_clk),
        .next_activation  (next_activation),
        .partial_sum_out  (partial_sum_out),
        .error_product_out(error_product_out),
        .error_out        (error_out)
    );

    task automatic drive(input act_t w, input act_t a, input psum_t ps,
                         input logic ei, input prod_t ep);
        weight           = w;
        activation       = a;
        partial_sum_in   = ps;
        error_in         = ei;
        error_product_in = ep;
    endtask

    // one cycle: optional late change of psin inside the check window
    task automatic cycle(input logic late, input psum_t late_ps);
        @(posedge clk);
        if (late) begin
            #1 partial_sum_in = late_ps;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(8'h00, 8'h00, 24'h0, 1'b0, 16'h0);
        @(negedge clk);
        total++;
        if (partial_sum_out !== 24'h0 || error_out !== 1'b0 ||
            error_product_out !== 16'h0 || next_activation !== 8'h00)
            $display("FAIL reset: psum=%h err=%b ep=%h na=%h, want all 0",
                     partial_sum_out, error_out, error_product_out, next_activation);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_mac;
        drive(8'h10, 8'h02, 24'h004000, 1'b0, 16'h0);
        cycle(1'b0, '0);
        total++;
        if (partial_sum_out !== 24'h004020)
            $display("FAIL clean_psum: got %h want 004020", partial_sum_out);
        else passed++;
        total++;
        if (error_out !== 1'b0 || error_product_out !== 16'h0)
            $display("FAIL clean_err: got err=%b ep=%h want 0/0000",
                     error_out, error_product_out);
        else passed++;
    endtask

    task automatic test_late_arrival;
        drive(8'h10, 8'h02, 24'h004000, 1'b0, 16'h0);
        cycle(1'b1, 24'h008000);
        total++;
        if (error_out !== 1'b1)
            $display("FAIL late_err: got %b want 1", error_out);
        else passed++;
        total++;
        if (partial_sum_out !== 24'h008000)
            $display("FAIL late_psum: got %h want 008000", partial_sum_out);
        else passed++;
        total++;
        if (error_product_out !== 16'h0020)
            $display("FAIL late_eprod: got %h want 0020", error_product_out);
        else passed++;
        // stable input next cycle clears the error
        cycle(1'b0, '0);
        total++;
        if (error_out !== 1'b0 || partial_sum_out !== 24'h008020)
            $display("FAIL late_recover: got err=%b psum=%h want 0/008020",
                     error_out, partial_sum_out);
        else passed++;
    endtask

    task automatic test_compensation;
        drive(8'h20, 8'h03, 24'h001000, 1'b1, 16'h0012);
        cycle(1'b0, '0);
        total++;
        if (partial_sum_out !== 24'h001072)
            $display("FAIL comp_psum: got %h want 001072", partial_sum_out);
        else passed++;
        total++;
        if (error_out !== 1'b0 || error_product_out !== 16'h0)
            $display("FAIL comp_err: got err=%b ep=%h want 0/0000",
                     error_out, error_product_out);
        else passed++;
    endtask

    task automatic test_both_errors;
        drive(8'h10, 8'h02, 24'h002000, 1'b1, 16'h0012);
        cycle(1'b1, 24'h006000);
        total++;
        if (partial_sum_out !== 24'h006012)
            $display("FAIL both_psum: got %h want 006012", partial_sum_out);
        else passed++;
        total++;
        if (error_out !== 1'b1 || error_product_out !== 16'h0020)
            $display("FAIL both_err: got err=%b ep=%h want 1/0020",
                     error_out, error_product_out);
        else passed++;
    endtask

    task automatic test_wrap_forward;
        drive(8'h01, 8'h01, 24'hFFFFFF, 1'b0, 16'h0);
        cycle(1'b0, '0);
        total++;
        if (partial_sum_out !== 24'h000000)
            $display("FAIL wrap_psum: got %h want 000000", partial_sum_out);
        else passed++;
        // max product path
        drive(8'hFF, 8'hFF, 24'h000001, 1'b1, 16'hFFFF);
        cycle(1'b0, '0);
        total++;
        if (partial_sum_out !== 24'h01FE01)
            $display("FAIL max_psum: got %h want 01fe01", partial_sum_out);
        else passed++;
        activation = 8'hA5;
        #1;
        total++;
        if (next_activation !== 8'hFF)
            $display("FAIL fwd_before: got %h want ff", next_activation);
        else passed++;
        cycle(1'b0, '0);
        total++;
        if (next_activation !== 8'hA5)
            $display("FAIL fwd_after: got %h want a5", next_activation);
        else passed++;
    endtask

    task automatic test_reset_mid;
        drive(8'h10, 8'h02, 24'h004000, 1'b0, 16'h0);
        cycle(1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (partial_sum_out !== 24'h0 || error_out !== 1'b0 ||
            error_product_out !== 16'h0 || next_activation !== 8'h00)
            $display("FAIL mid_reset: psum=%h err=%b ep=%h na=%h, want all 0",
                     partial_sum_out, error_out, error_product_out, next_activation);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h03, 8'h05, 24'h000100, 1'b0, 16'h0);
        cycle(1'b0, '0);
        total++;
        if (partial_sum_out !== 24'h00010F || error_out !== 1'b0 ||
            next_activation !== 8'h05)
            $display("FAIL resume: psum=%h err=%b na=%h want 00010f/0/05",
                     partial_sum_out, error_out, next_activation);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_mac();
        test_late_arrival();
        test_compensation();
        test_both_errors();
        test_wrap_forward();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
